// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and defaults for the skid-buffered pipeline stage
package pipe_ctrl_pkg;

    // Occupancy of the stage: main bank is the head, skid bank is second in line
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    localparam int PAYLOAD_W_DEF = 154;
    localparam int CNT_W_DEF     = 16;

endpackage

// File: rtl/pipe_data_bank.sv
// rtl/pipe_data_bank.sv - payload bank built from per-bit enable flops
module pipe_data_bank #(
    parameter int W = 154
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         softReset,
    input  logic         enable,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    for (genvar i = 0; i < W; i++) begin : g_cell
        logic cell_q;

        // One enable flop per bit: cleared on reset or softReset, loads only when enabled
        always_ff @(posedge clk) begin
            if (!reset) begin
                cell_q <= 1'b0;
            end else if (softReset) begin
                cell_q <= 1'b0;
            end else if (enable) begin
                cell_q <= d[i];
            end
        end

        assign q[i] = cell_q;
    end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - skid-buffered stage controller; PIPE_STALL_CNT_EN adds stall_cnt
module pipe_stage_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 softReset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt
`endif
);

    stage_state_t           state;
    stage_state_t           next_state;
    logic                   in_fire;
    logic                   out_fire;
    logic                   main_en;
    logic                   skid_en;
    logic [PAYLOAD_W-1:0]   main_d;
    logic [PAYLOAD_W-1:0]   main_q;
    logic [PAYLOAD_W-1:0]   skid_q;

    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_data  = main_q;

    // Next occupancy and bank load strobes; a flush suppresses every load
    always_comb begin
        next_state = state;
        main_en    = 1'b0;
        skid_en    = 1'b0;
        main_d     = in_data;
        if (softReset) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        next_state = HALF;
                        main_en    = 1'b1;
                    end
                end
                HALF: begin
                    if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end else if (in_fire) begin
                        next_state = FULL;
                        skid_en    = 1'b1;
                    end else if (out_fire) begin
                        next_state = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        next_state = HALF;
                        main_en    = 1'b1;
                        main_d     = skid_q;
                    end
                end
                default: begin
                    next_state = EMPTY;
                end
            endcase
        end
    end

    // State register; in_ready is registered from next state so it never sees out_ready combinationally
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != FULL);
        end
    end

    pipe_data_bank #(.W(PAYLOAD_W)) u_main_bank (
        .clk       (clk),
        .reset     (reset),
        .softReset (1'b0),
        .enable    (main_en),
        .d         (main_d),
        .q         (main_q)
    );

    pipe_data_bank #(.W(PAYLOAD_W)) u_skid_bank (
        .clk       (clk),
        .reset     (reset),
        .softReset (1'b0),
        .enable    (skid_en),
        .d         (in_data),
        .q         (skid_q)
    );

`ifdef PIPE_STALL_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating count of cycles the head entry waited on downstream
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (softReset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb/tb_pipe_stage_ctrl.sv - scoreboard bench for pipe_stage_ctrl
module tb_pipe_stage_ctrl;

    localparam int W = 154;

    logic         clk = 1'b0;
    logic         reset;
    logic         softReset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] q[$];
    logic         of;
    logic [W-1:0] od;
    logic [W-1:0] exp_d;

`ifdef PIPE_STALL_CNT_EN
    logic [15:0]  stall_cnt;
    logic         in_ready4;
    logic         out_valid4;
    logic [W-1:0] out_data4;
    logic [3:0]   stall_cnt4;
`endif

    always #5 clk = ~clk;

    pipe_stage_ctrl #(.PAYLOAD_W(W), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .softReset (softReset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

`ifdef PIPE_STALL_CNT_EN
    pipe_stage_ctrl #(.PAYLOAD_W(W), .CNT_W(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .softReset (softReset),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .in_data   (in_data),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_data  (out_data4),
        .stall_cnt (stall_cnt4)
    );
`endif

    function automatic logic [W-1:0] mkd(input int unsigned k);
        logic [31:0] v;
        v = k;
        return {v[25:0], v, ~v, v, ~v};
    endfunction

    // Advance one clock; record an accepted input in the scoreboard, report any output transfer
    task automatic step(output logic ofire, output logic [W-1:0] odata);
        if (in_valid && in_ready && reset && !softReset) q.push_back(in_data);
        ofire = out_valid && out_ready;
        odata = out_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; softReset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        step(of, od);
        step(of, od);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data got %0h want 0", out_data); end
        reset = 1'b1;
        step(of, od);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_in_ready got %0b want 1", in_ready); end
        q.delete();
    endtask

    task automatic test_stream();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) in_data = mkd(k + 1); else in_valid = 1'b0;
            step(of, od);
            if (of) begin
                n_cmp++;
                if (q.size() == 0) begin n_bad++; $display("FAIL stream_extra got %0h want none", od); end
                else begin exp_d = q.pop_front(); if (od !== exp_d) begin n_bad++; $display("FAIL stream_data got %0h want %0h", od, exp_d); end end
            end
            if (k < 3) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready got %0b want 1", in_ready); end
                n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_latency got %0b want 1", out_valid); end
            end
        end
        n_cmp++; if (q.size() != 0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drain left %0d valid %0b want 0 0", q.size(), out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = mkd(32'hA0); step(of, od);
        in_data = mkd(32'hB0); step(of, od);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_in_ready got %0b want 0", in_ready); end
        n_cmp++; if (out_data !== mkd(32'hA0)) begin n_bad++; $display("FAIL bp_head got %0h want %0h", out_data, mkd(32'hA0)); end
        in_data = mkd(32'hC0); out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) in_valid = 1'b0;
            step(of, od);
            if (k == 0) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_return got %0b want 1", in_ready); end
            end
            if (of) begin
                n_cmp++;
                if (q.size() == 0) begin n_bad++; $display("FAIL bp_extra got %0h want none", od); end
                else begin exp_d = q.pop_front(); if (od !== exp_d) begin n_bad++; $display("FAIL bp_data got %0h want %0h", od, exp_d); end end
            end
        end
        n_cmp++; if (q.size() != 0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain left %0d valid %0b want 0 0", q.size(), out_valid); end
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = mkd(32'hA1); step(of, od);
        in_data = mkd(32'hB1); step(of, od);
        in_valid = 1'b0; softReset = 1'b1;
        step(of, od);
        softReset = 1'b0; q.delete();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready got %0b want 1", in_ready); end
        in_valid = 1'b1; in_data = mkd(32'hD1); out_ready = 1'b1;
        step(of, od);
        in_valid = 1'b0;
        step(of, od);
        n_cmp++;
        if (!of || q.size() == 0) begin n_bad++; $display("FAIL flush_next got fire %0b want 1", of); end
        else begin exp_d = q.pop_front(); if (od !== exp_d) begin n_bad++; $display("FAIL flush_next_data got %0h want %0h", od, exp_d); end end
    endtask

    task automatic test_flush_infire();
        out_ready = 1'b1; in_valid = 1'b1; in_data = mkd(32'hE2); softReset = 1'b1;
        step(of, od);
        softReset = 1'b0; in_valid = 1'b0; q.delete();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_infire_valid got %0b want 0", out_valid); end
        in_valid = 1'b1; in_data = mkd(32'hF2); out_ready = 1'b0;
        step(of, od);
        in_valid = 1'b0; out_ready = 1'b1; softReset = 1'b1;
        step(of, od);
        softReset = 1'b0;
        n_cmp++;
        if (!of || q.size() == 0) begin n_bad++; $display("FAIL flush_outfire got fire %0b want 1", of); end
        else begin exp_d = q.pop_front(); if (od !== exp_d) begin n_bad++; $display("FAIL flush_outfire_data got %0h want %0h", od, exp_d); end end
        q.delete();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_outfire_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_midstream_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = mkd(32'h51); step(of, od);
        in_data = mkd(32'h52); step(of, od);
        in_valid = 1'b0; reset = 1'b0;
        step(of, od);
        q.delete();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_reset_in_ready got %0b want 0", in_ready); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL mid_reset_data got %0h want 0", out_data); end
        reset = 1'b1; out_ready = 1'b1;
        step(of, od);
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_release got ready %0b valid %0b want 1 0", in_ready, out_valid); end
    endtask

`ifdef PIPE_STALL_CNT_EN
    task automatic test_stall_cnt();
        out_ready = 1'b0; in_valid = 1'b1; in_data = mkd(32'h77);
        step(of, od);
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) step(of, od);
        n_cmp++; if (stall_cnt !== 16'd10) begin n_bad++; $display("FAIL stall_10 got %0d want 10", stall_cnt); end
        softReset = 1'b1; step(of, od); softReset = 1'b0; q.delete();
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL stall_clear got %0d want 0", stall_cnt); end
        in_valid = 1'b1; step(of, od); in_valid = 1'b0;
        for (int k = 0; k < 20; k++) step(of, od);
        n_cmp++; if (stall_cnt4 !== 4'd15) begin n_bad++; $display("FAIL stall_sat got %0d want 15", stall_cnt4); end
        n_cmp++; if (stall_cnt !== 16'd20) begin n_bad++; $display("FAIL stall_20 got %0d want 20", stall_cnt); end
        softReset = 1'b1; step(of, od); softReset = 1'b0; q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_flush_infire();
        test_midstream_reset();
`ifdef PIPE_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_ctrl.md
Name: pipe_stage_ctrl

Overview:
- Skid-buffered pipeline-stage controller that sits between two back-end stages of the out-of-order core.
- Sequences two enable-DFF payload banks (main, skid) with a valid/ready handshake.
- Upstream stalls never combinationally depend on downstream ready.
- Provides a pipeline flush (softReset) that drops in-flight entries without clearing payload storage.

Parameters:
- PAYLOAD_W, 154, width in bits of the per-stage payload.
- CNT_W, 16, width of the optional stall counter.

Ports:
- clk  input  1  stage clock; all state changes on posedge clk.
- reset  input  1  synchronous, active-low reset (0 = reset asserted).
- softReset  input  1  synchronous flush, active-high.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept; registered.
- in_data  input  PAYLOAD_W  upstream payload.
- out_valid  output  1  stage holds a valid entry.
- out_ready  input  1  downstream accepts.
- out_data  output  PAYLOAD_W  head payload (main bank q).
- stall_cnt  output  CNT_W  present only with PIPE_STALL_CNT_EN.

Behaviour:
- Handshakes:
  - Upstream fire: in_fire = in_valid & in_ready.
  - Downstream fire: out_fire = out_valid & out_ready.
- States:
  - EMPTY (0 entries).
  - HALF (main valid).
  - FULL (main and skid valid).
- Outputs derived from state:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL) and not in reset; it is a flop output.
- Reset (reset==0 at posedge):
  - State goes to EMPTY; main and skid banks clear to 0.
  - out_valid=0, in_ready=0, stall_cnt=0.
  - in_ready rises on the first posedge with reset==1.
- Priority order: reset > softReset > handshake transitions.
- Transitions:
  - EMPTY: in_fire -> HALF, main<=in_data.
  - HALF:
    - in_fire & out_fire -> HALF, main<=in_data.
    - in_fire only -> FULL, skid<=in_data.
    - out_fire only -> EMPTY.
    - Neither -> hold.
  - FULL:
    - out_fire -> HALF, main<=skid.
    - in_valid is ignored because in_ready=0.
- Bank enables:
  - main enabled only on the loads listed above.
  - skid enabled only on the HALF->FULL load.
  - Banks hold their value otherwise.
- Latency: an accepted entry appears on out_data/out_valid the following cycle. Throughput is 1 per cycle while out_ready=1.
- Ordering: strict FIFO; the skid entry is never presented before main.
- Flush (softReset==1 with reset==1):
  - Next state is EMPTY and in_ready=1.
  - Payload banks keep their contents (stale but invalid).
  - Any in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle is still a completed transfer downstream.
- Simultaneous softReset and reset: reset wins.
- Reset mid-stream: all entries are lost and nothing further is emitted.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared by reset and by softReset.
- Undefined: the stall_cnt port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg:
  - typedef enum logic [1:0] {EMPTY, HALF, FULL} stage_state_t.
  - localparam PAYLOAD_W_DEF = 154.
  - localparam CNT_W_DEF = 16.
- Sub-module pipe_data_bank:
  - Parameterised array of enableD_FF cells, each with q/d/reset/softReset/enable/clk.
  - Instantiated twice (main, skid).
  - softReset is tied low on the banks so a flush does not clear data.

Test Plan:
- Reset then stream: reset low 2 cycles, then in_valid=1 with data 1,2,3 and out_ready=1 -> out_data 1,2,3 on consecutive cycles, each 1 cycle after acceptance; in_ready stays 1.
- Backpressure: out_ready=0 and send A,B -> state FULL, in_ready=0 after B. Then out_ready=1 -> A, then B, then out_valid=0; C held upstream until in_ready returns to 1.
- Flush in FULL: hold A,B, assert softReset 1 cycle -> next cycle out_valid=0, in_ready=1. A later input D emerges as the next output, with no A or B.
- Flush with simultaneous in_fire(E): E is never output; out_valid=0 the following cycle.
- Mid-stream reset: in FULL, pull reset low -> out_valid=0, in_ready=0, out_data=0. In_ready=1 on the first cycle after release.
- PIPE_STALL_CNT_EN: hold out_valid with out_ready=0 for 10 cycles -> stall_cnt=10. softReset -> 0. With CNT_W=4 and a 20-cycle stall -> stall_cnt saturates at 15.
